// File: rtl/srd_pkg.sv
// Shared types and helpers for the spike rate decoder: FSM states, default
// sizing constants and a saturating increment.
package srd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } srd_state_e;

   localparam int SRD_N_OUT   = 8;
   localparam int SRD_CNT_W   = 8;
   localparam int SRD_WIN_LEN = 256;

   // Increment v, holding at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_v;
      max_v = (32'd1 << w) - 32'd1;
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/srd_argmax_scan.sv
// Sequential argmax over the counter bank: one compare per cycle, lowest index
// wins ties. done pulses the cycle after the last index has been compared.
module srd_argmax_scan #(
   parameter int N_OUT = 8,
   parameter int CNT_W = 8,
   parameter int IDX_W = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_start,
   input  logic [CNT_W-1:0] cnt_sel,
   output logic [IDX_W-1:0] scan_idx,
   output logic [CNT_W-1:0] best,
   output logic [IDX_W-1:0] best_idx,
   output logic             tie,
   output logic             done
);

   logic active;

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_idx <= '0;
         active   <= 1'b0;
         best     <= '0;
         best_idx <= '0;
         tie      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (scan_start) begin
            // scan_idx is parked at 0 between scans, so cnt_sel is cnt[0] here
            best     <= cnt_sel;
            best_idx <= '0;
            tie      <= 1'b0;
            if (N_OUT == 1) begin
               done <= 1'b1;
            end else begin
               active   <= 1'b1;
               scan_idx <= IDX_W'(1);
            end
         end else if (active) begin
            if (cnt_sel > best) begin
               best     <= cnt_sel;
               best_idx <= scan_idx;
               tie      <= 1'b0;
            end else if (cnt_sel == best) begin
               tie <= 1'b1;
            end
            if (scan_idx == IDX_W'(N_OUT - 1)) begin
               active   <= 1'b0;
               done     <= 1'b1;
               scan_idx <= '0;
            end else begin
               scan_idx <= scan_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate classifier: counts output spikes over a window, scans for argmax,
// presents the result on a valid/ready port. SRD_AUTO_RESTART_EN re-arms after each result.
module spike_rate_decoder
   import srd_pkg::*;
#(
   parameter int N_OUT   = SRD_N_OUT,
   parameter int CNT_W   = SRD_CNT_W,
   parameter int WIN_LEN = SRD_WIN_LEN,
   parameter int IDX_W   = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             spk_valid,
   input  logic [N_OUT-1:0] spk_in,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [IDX_W-1:0] winner,
   output logic [CNT_W-1:0] winner_count,
   output logic             tie,
   output logic             no_spike,
   output logic             overrun
);

   localparam int STEP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   srd_state_e                      state;
   logic [STEP_W-1:0]               step;
   logic [N_OUT-1:0][CNT_W-1:0]     cnt;
   logic [N_OUT-1:0][CNT_W-1:0]     cnt_nxt;
   logic                            cnt_clr;
   logic                            cnt_inc;
   logic                            restart;
   logic                            scan_start;
   logic                            scan_done;
   logic [IDX_W-1:0]                scan_idx;
   logic [CNT_W-1:0]                cnt_sel;
   logic [CNT_W-1:0]                best;
   logic [IDX_W-1:0]                best_idx;
   logic                            best_tie;

`ifdef SRD_AUTO_RESTART_EN
   assign restart = (state == DONE) && result_ready;
`else
   assign restart = 1'b0;
`endif

   assign cnt_clr = ((state == IDLE) && start) || restart;
   assign cnt_inc = (state == ACCUM) && spk_valid;
   assign busy    = (state == ACCUM) || (state == SCAN);
   assign cnt_sel = cnt[scan_idx];

   for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      always_comb begin
         cnt_nxt[i] = cnt[i];
         if (cnt_clr)
            cnt_nxt[i] = '0;
         else if (cnt_inc && spk_in[i])
            cnt_nxt[i] = CNT_W'(sat_inc(32'(cnt[i]), CNT_W));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         step         <= '0;
         overrun      <= 1'b0;
         scan_start   <= 1'b0;
         result_valid <= 1'b0;
         winner       <= '0;
         winner_count <= '0;
         tie          <= 1'b0;
         no_spike     <= 1'b0;
      end else begin
         scan_start <= 1'b0;
         case (state)
            IDLE: begin
               // start takes priority; a coincident spk_valid is neither counted nor flagged
               if (start) begin
                  step    <= '0;
                  overrun <= 1'b0;
                  state   <= ACCUM;
               end else if (spk_valid) begin
                  overrun <= 1'b1;
               end
            end
            ACCUM: begin
               if (spk_valid) begin
                  if (step == STEP_W'(WIN_LEN - 1)) begin
                     step       <= '0;
                     scan_start <= 1'b1;
                     state      <= SCAN;
                  end else begin
                     step <= step + 1'b1;
                  end
               end
            end
            SCAN: begin
               if (spk_valid) overrun <= 1'b1;
               if (scan_done) begin
                  winner       <= best_idx;
                  winner_count <= best;
                  tie          <= best_tie;
                  no_spike     <= (best == '0);
                  result_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (spk_valid) overrun <= 1'b1;
               if (result_ready) begin
                  result_valid <= 1'b0;
                  step         <= '0;
                  state        <= restart ? ACCUM : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   srd_argmax_scan #(
      .N_OUT (N_OUT),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .scan_start (scan_start),
      .cnt_sel    (cnt_sel),
      .scan_idx   (scan_idx),
      .best       (best),
      .best_idx   (best_idx),
      .tie        (best_tie),
      .done       (scan_done)
   );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: two decoder instances (8-bit/16-step and 4-bit/20-step),
// directed windows push expected results, negedge monitors pop on handshake.
module tb_spike_rate_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start0, sv0, rdy0;
   logic [7:0] si0;
   logic       busy0, rv0, tie0, ns0, ovr0;
   logic [2:0] win0;
   logic [7:0] wc0;

   logic       start1, sv1, rdy1;
   logic [7:0] si1;
   logic       busy1, rv1, tie1, ns1, ovr1;
   logic [2:0] win1;
   logic [3:0] wc1;

   spike_rate_decoder #(.N_OUT(8), .CNT_W(8), .WIN_LEN(16)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .spk_valid(sv0), .spk_in(si0),
      .busy(busy0), .result_valid(rv0), .result_ready(rdy0), .winner(win0),
      .winner_count(wc0), .tie(tie0), .no_spike(ns0), .overrun(ovr0));

   spike_rate_decoder #(.N_OUT(8), .CNT_W(4), .WIN_LEN(20)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .spk_valid(sv1), .spk_in(si1),
      .busy(busy1), .result_valid(rv1), .result_ready(rdy1), .winner(win1),
      .winner_count(wc1), .tie(tie1), .no_spike(ns1), .overrun(ovr1));

   typedef struct packed {
      logic [2:0] w;
      logic [7:0] c;
      logic       t;
      logic       z;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rv0 && rdy0) begin
         if (q0.size() == 0) chk("dut0 unexpected result", 32'd1, 32'd0);
         else begin
            e0 = q0.pop_front();
            chk("dut0 winner",       32'(win0), 32'(e0.w));
            chk("dut0 winner_count", 32'(wc0),  32'(e0.c));
            chk("dut0 tie",          32'(tie0), 32'(e0.t));
            chk("dut0 no_spike",     32'(ns0),  32'(e0.z));
         end
      end
      if (!reset && rv1 && rdy1) begin
         if (q1.size() == 0) chk("dut1 unexpected result", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("dut1 winner",       32'(win1), 32'(e1.w));
            chk("dut1 winner_count", 32'(wc1),  32'(e1.c));
            chk("dut1 tie",          32'(tie1), 32'(e1.t));
            chk("dut1 no_spike",     32'(ns1),  32'(e1.z));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_0();
      start0 = 1'b1; tick(); start0 = 1'b0;
   endtask

   task automatic step0(input logic [7:0] s);
      sv0 = 1'b1; si0 = s; tick(); sv0 = 1'b0; si0 = '0;
   endtask

   task automatic step1(input logic [7:0] s);
      sv1 = 1'b1; si1 = s; tick(); sv1 = 1'b0; si1 = '0;
   endtask

   task automatic wait_rv0(output int n);
      n = 0;
      while (!rv0 && n < 40) begin tick(); n++; end
   endtask

   task automatic wait_rv1(output int n);
      n = 0;
      while (!rv1 && n < 40) begin tick(); n++; end
   endtask

   int n;

   initial begin
      reset = 1'b1;
      start0 = 0; sv0 = 0; si0 = '0; rdy0 = 1'b1;
      start1 = 0; sv1 = 0; si1 = '0; rdy1 = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("reset busy",         32'(busy0), 32'd0);
      chk("reset result_valid", 32'(rv0),   32'd0);
      chk("reset winner",       32'(win0),  32'd0);
      chk("reset winner_count", 32'(wc0),   32'd0);
      chk("reset tie/no_spike", 32'({tie0, ns0, ovr0}), 32'd0);

      // clear winner: neuron 5 every step, neuron 2 on even steps
      q0.push_back('{w: 3'd5, c: 8'd16, t: 1'b0, z: 1'b0});
      start_0();
      chk("busy after start", 32'(busy0), 32'd1);
      for (int k = 0; k < 16; k++) step0(8'h20 | ((k % 2 == 0) ? 8'h04 : 8'h00));
      wait_rv0(n);
      chk("latency after final step", 32'(n), 32'd9);
      tick();

      // tie between neurons 1 and 6
      q0.push_back('{w: 3'd1, c: 8'd7, t: 1'b1, z: 1'b0});
      start_0();
      for (int k = 0; k < 16; k++) step0((k < 7) ? 8'h42 : 8'h00);
      wait_rv0(n);
      chk("tie window completes", 32'(rv0), 32'd1);
      tick();

      // silence; the step coincident with start must not count
      q0.push_back('{w: 3'd0, c: 8'd0, t: 1'b1, z: 1'b1});
`ifndef SRD_AUTO_RESTART_EN
      start0 = 1'b1; sv0 = 1'b1; si0 = 8'h01; tick();
      start0 = 1'b0; sv0 = 1'b0; si0 = '0;
`else
      start_0();
`endif
      for (int k = 0; k < 16; k++) step0(8'h00);
      wait_rv0(n);
      chk("silence window completes", 32'(rv0), 32'd1);
      tick();

      // saturation on the 4-bit instance, with gaps in spk_valid
      q1.push_back('{w: 3'd3, c: 8'd15, t: 1'b0, z: 1'b0});
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step1(8'h08 | ((k < 5) ? 8'h01 : 8'h00));
         if (k % 3 == 0) tick();
         if (k == 15) chk("dut1 busy after 16 gapped steps", 32'(busy1), 32'd1);
      end
      wait_rv1(n);
      chk("dut1 latency", 32'(n), 32'd9);
      tick();

      // handshake stall with overrun
      rdy0 = 1'b0;
      q0.push_back('{w: 3'd7, c: 8'd3, t: 1'b0, z: 1'b0});
      start_0();
      for (int k = 0; k < 16; k++) step0((k < 3) ? 8'h80 : 8'h00);
      wait_rv0(n);
      chk("stall result_valid", 32'(rv0), 32'd1);
      for (int k = 0; k < 10; k++) begin
         sv0 = 1'b1; si0 = 8'hff; tick();
         chk("stall winner stable", 32'(win0), 32'd7);
         chk("stall count stable",  32'(wc0),  32'd3);
         chk("stall valid held",    32'(rv0),  32'd1);
      end
      sv0 = 1'b0; si0 = '0;
      chk("overrun sticky", 32'(ovr0), 32'd1);
      rdy0 = 1'b1;
      tick();
      chk("valid drops after handshake", 32'(rv0),  32'd0);
      chk("winner persists",             32'(win0), 32'd7);
`ifndef SRD_AUTO_RESTART_EN
      chk("idle after handshake", 32'(busy0), 32'd0);
`endif
      start_0();
`ifndef SRD_AUTO_RESTART_EN
      chk("start clears overrun", 32'(ovr0), 32'd0);
`endif

      // reset mid-window
      for (int k = 0; k < 8; k++) step0(8'hff);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid reset busy",   32'(busy0), 32'd0);
      chk("mid reset valid",  32'(rv0),   32'd0);
      chk("mid reset winner", 32'(win0),  32'd0);
      chk("mid reset count",  32'(wc0),   32'd0);
      chk("mid reset flags",  32'({tie0, ns0, ovr0}), 32'd0);

      q0.push_back('{w: 3'd4, c: 8'd16, t: 1'b0, z: 1'b0});
      start_0();
      for (int k = 0; k < 16; k++) step0(8'h10 | ((k < 10) ? 8'h01 : 8'h00));
      wait_rv0(n);
      chk("fresh window latency", 32'(n), 32'd9);
      tick();

`ifdef SRD_AUTO_RESTART_EN
      q0.push_back('{w: 3'd6, c: 8'd16, t: 1'b0, z: 1'b0});
      for (int k = 0; k < 16; k++) step0(8'h40);
      wait_rv0(n);
      chk("auto restart window", 32'(n), 32'd9);
      tick();
`endif

      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin tick(); n++; end
      chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
      chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
